// File: rtl/mont_pkg.sv
// Shared definitions for the radix-2 Montgomery multiplier and the
// exponentiation controller that drives it.
package mont_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      SUB  = 2'd2
   } state_t;

   // Width of an MSB-index field for a given operand width.
   function automatic int calc_len_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: A' = (A + x_bit*y + q*n) / 2.
// Kept separate so a higher-radix or carry-save step can drop in later.
module mont_step #(
   parameter int WIDTH = 2048
) (
   input  logic [WIDTH+1:0] a,
   input  logic             x_bit,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH+1:0] a_next
);

   logic             q;
   logic [WIDTH+2:0] sum;

   always_comb begin
      q      = a[0] ^ (x_bit & y[0]);
      // q forces the sum even, so the shift below discards nothing.
      sum    = {1'b0, a}
             + ({(WIDTH+3){x_bit}} & {3'b000, y})
             + ({(WIDTH+3){q}}     & {3'b000, n});
      a_next = (WIDTH+2)'(sum >> 1);
   end

endmodule

// File: rtl/mont_mul_param.sv
// Handshaked radix-2 Montgomery multiplier: result = x*y*2^-(n_len+1) mod n,
// fully reduced, with operand latching, abort and one-cycle done pulse.
module mont_mul_param
   import mont_pkg::*;
#(
   parameter int WIDTH = 2048,
   parameter int LEN_W = calc_len_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] n,
   input  logic [LEN_W-1:0] n_len,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH - 1);

   state_t             state, state_next;
   logic               load, step, finish;
   logic [WIDTH+1:0]   a, a_step;
   logic [LEN_W-1:0]   i, len_r, len_sat;
   logic [WIDTH-1:0]   x_r, y_r, n_r, result_next;

   // Saturation only exists when n_len can encode indices beyond WIDTH-1.
   if ((2 ** LEN_W) > WIDTH) begin : g_sat
      assign len_sat = (n_len > LEN_MAX) ? LEN_MAX : n_len;
   end else begin : g_nosat
      assign len_sat = n_len;
   end

   mont_step #(.WIDTH(WIDTH)) u_step (
      .a      (a),
      .x_bit  (x_r[i]),
      .y      (y_r),
      .n      (n_r),
      .a_next (a_step)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can infer a latch.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = MUL;
            end
         end
         MUL: begin
            if (abort) begin
               state_next = IDLE;
            end else begin
               step = 1'b1;
               if (i == len_r) state_next = SUB;
            end
         end
         SUB: begin
            state_next = IDLE;
            finish     = !abort;
         end
         default: state_next = IDLE;
      endcase
   end

   // A < 2n after the multiply loop, so one conditional subtract reduces it.
   always_comb begin
      if (a >= {2'b00, n_r}) result_next = WIDTH'(a - {2'b00, n_r});
      else                   result_next = a[WIDTH-1:0];
   end

   // NOTE: operand latches are reset as well, so the step datapath never
   // sees undefined values even before the first accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a      <= '0;
         i      <= '0;
         x_r    <= '0;
         y_r    <= '0;
         n_r    <= '0;
         len_r  <= '0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            x_r   <= x;
            y_r   <= y;
            n_r   <= n;
            len_r <= len_sat;
            a     <= '0;
            i     <= '0;
         end
         if (step) begin
            a <= a_step;
            if (i != len_r) i <= i + LEN_W'(1);
         end
         if (finish) result <= result_next;
      end
   end

endmodule

// File: tb/tb_mont_mul_param.sv
// Self-checking bench: directed 8-bit scenarios plus randomized 2048-bit
// operations against a modular-halving reference model.
module tb_mont_mul_param;

   localparam int WB = 2048;
   localparam int LB = 11;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          s_start, s_abort, s_busy, s_done;
   logic [7:0]    s_x, s_y, s_n, s_result;
   logic [2:0]    s_len;

   logic          w_start, w_abort, w_busy, w_done;
   logic [WB-1:0] w_x, w_y, w_n, w_result;
   logic [LB-1:0] w_len;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [7:0]    last8    = 8'd0;

   mont_mul_param #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
      .x(s_x), .y(s_y), .n(s_n), .n_len(s_len),
      .busy(s_busy), .done(s_done), .result(s_result)
   );

   mont_mul_param #(.WIDTH(WB)) dut (
      .clk(clk), .rst_n(rst_n), .start(w_start), .abort(w_abort),
      .x(w_x), .y(w_y), .n(w_n), .n_len(w_len),
      .busy(w_busy), .done(w_done), .result(w_result)
   );

   // x*y mod n, then divide by 2 modulo n once per iteration.
   function automatic logic [WB-1:0] ref_mont(input logic [WB-1:0] a, b, m, input int steps);
      logic [2*WB-1:0] prod;
      logic [WB:0]     p;
      prod = {{WB{1'b0}}, a} * {{WB{1'b0}}, b};
      p    = (WB+1)'(prod % {{WB{1'b0}}, m});
      for (int k = 0; k < steps; k++)
         p = p[0] ? ((p + {1'b0, m}) >> 1) : (p >> 1);
      return p[WB-1:0];
   endfunction

   function automatic logic [WB-1:0] rand_wide();
      logic [WB-1:0] r;
      for (int w = 0; w < WB / 32; w++) r[w*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op8(input logic [7:0] xv, yv, nv, input logic [2:0] lv,
                      input logic [7:0] exp, input logic with_abort, input string tag);
      int t, busy_cnt;
      s_x = xv; s_y = yv; s_n = nv; s_len = lv;
      s_start = 1'b1; s_abort = with_abort;
      tick();
      s_start = 1'b0; s_abort = 1'b0;
      t = 0; busy_cnt = 0;
      while (s_done !== 1'b1 && t < 40) begin
         if (s_busy === 1'b1) busy_cnt++;
         tick();
         t++;
      end
      n_checks++;
      if (s_done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s done: not seen within %0d cycles", tag, t);
         return;
      end
      n_checks++;
      if (t != int'(lv) + 2) begin
         n_fail++; $display("FAIL %s latency: got %0d expected %0d", tag, t, int'(lv) + 2);
      end
      n_checks++;
      if (busy_cnt != int'(lv) + 2) begin
         n_fail++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cnt, int'(lv) + 2);
      end
      n_checks++;
      if (s_busy !== 1'b0) begin
         n_fail++; $display("FAIL %s busy_in_done: got %b expected 0", tag, s_busy);
      end
      n_checks++;
      if (s_result !== exp) begin
         n_fail++; $display("FAIL %s result: got %0d expected %0d", tag, s_result, exp);
      end
      n_checks++;
      if (!(s_result < nv)) begin
         n_fail++; $display("FAIL %s reduced: got %0d expected below %0d", tag, s_result, nv);
      end
      last8 = exp;
      tick();
      n_checks++;
      if (s_done !== 1'b0) begin
         n_fail++; $display("FAIL %s done_pulse: got %b expected 0", tag, s_done);
      end
      n_checks++;
      if (s_result !== exp) begin
         n_fail++; $display("FAIL %s result_hold: got %0d expected %0d", tag, s_result, exp);
      end
   endtask

   task automatic test_reset();
      repeat (2) tick();
      n_checks++;
      if (s_busy !== 1'b0 || s_done !== 1'b0) begin
         n_fail++; $display("FAIL reset8 ctl: got busy=%b done=%b expected 0 0", s_busy, s_done);
      end
      n_checks++;
      if (s_result !== 8'd0) begin
         n_fail++; $display("FAIL reset8 result: got %0d expected 0", s_result);
      end
      n_checks++;
      if (w_busy !== 1'b0 || w_done !== 1'b0) begin
         n_fail++; $display("FAIL reset2048 ctl: got busy=%b done=%b expected 0 0", w_busy, w_done);
      end
      n_checks++;
      if (w_result !== '0) begin
         n_fail++; $display("FAIL reset2048 result: got low %h expected 0", w_result[63:0]);
      end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (s_busy !== 1'b0 || w_busy !== 1'b0) begin
         n_fail++; $display("FAIL post_reset idle: got busy8=%b busy2048=%b expected 0 0", s_busy, w_busy);
      end
   endtask

   task automatic test_basic();
      op8(8'd5, 8'd7, 8'd13, 3'd3, 8'd3, 1'b0, "basic");
   endtask

   task automatic test_values();
      op8(8'd12, 8'd12, 8'd13, 3'd3, 8'd9, 1'b0, "x12y12");
      op8(8'd0,  8'd7,  8'd13, 3'd3, 8'd0, 1'b0, "x0y7");
      op8(8'd5,  8'd7,  8'd13, 3'd7, 8'd1, 1'b0, "len7");
      op8(8'd5,  8'd7,  8'd13, 3'd3, 8'd3, 1'b1, "start_with_abort");
   endtask

   task automatic test_start_ignored();
      int dones, done_t;
      logic [7:0] res;
      s_x = 8'd5; s_y = 8'd7; s_n = 8'd13; s_len = 3'd3; s_start = 1'b1;
      tick();
      s_start = 1'b0;
      repeat (2) tick();
      s_start = 1'b1; s_x = 8'd12; s_y = 8'd12; s_n = 8'd11; s_len = 3'd7;
      tick();
      s_start = 1'b0;
      dones = 0; done_t = -1; res = 8'd0;
      for (int t = 3; t < 15; t++) begin
         if (s_done === 1'b1) begin
            dones++;
            if (done_t < 0) begin done_t = t; res = s_result; end
         end
         tick();
      end
      n_checks++;
      if (dones != 1) begin
         n_fail++; $display("FAIL ignore_start done_count: got %0d expected 1", dones);
      end
      n_checks++;
      if (done_t != 5) begin
         n_fail++; $display("FAIL ignore_start latency: got %0d expected 5", done_t);
      end
      n_checks++;
      if (res !== 8'd3) begin
         n_fail++; $display("FAIL ignore_start result: got %0d expected 3", res);
      end
      n_checks++;
      if (s_busy !== 1'b0) begin
         n_fail++; $display("FAIL ignore_start queued: got busy=%b expected 0", s_busy);
      end
      last8 = 8'd3;
   endtask

   task automatic abort_at(input int when, input string tag);
      int dones;
      s_x = 8'd12; s_y = 8'd12; s_n = 8'd13; s_len = 3'd3; s_start = 1'b1;
      tick();
      s_start = 1'b0;
      repeat (when) tick();
      s_abort = 1'b1;
      tick();
      s_abort = 1'b0;
      n_checks++;
      if (s_busy !== 1'b0) begin
         n_fail++; $display("FAIL %s busy: got %b expected 0", tag, s_busy);
      end
      dones = 0;
      repeat (8) begin
         if (s_done === 1'b1) dones++;
         tick();
      end
      n_checks++;
      if (dones != 0) begin
         n_fail++; $display("FAIL %s done_count: got %0d expected 0", tag, dones);
      end
      n_checks++;
      if (s_result !== last8) begin
         n_fail++; $display("FAIL %s result_kept: got %0d expected %0d", tag, s_result, last8);
      end
   endtask

   task automatic test_abort();
      abort_at(2, "abort_mul");
      abort_at(4, "abort_sub");
      op8(8'd12, 8'd12, 8'd13, 3'd3, 8'd9, 1'b0, "after_abort");
   endtask

   task automatic test_reset_mid();
      s_x = 8'd5; s_y = 8'd7; s_n = 8'd13; s_len = 3'd3; s_start = 1'b1;
      tick();
      s_start = 1'b0;
      repeat (2) tick();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (s_busy !== 1'b0 || s_done !== 1'b0 || s_result !== 8'd0) begin
         n_fail++;
         $display("FAIL async_reset: got busy=%b done=%b result=%0d expected 0 0 0", s_busy, s_done, s_result);
      end
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (s_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_release busy: got %b expected 0", s_busy);
      end
      op8(8'd5, 8'd7, 8'd13, 3'd3, 8'd3, 1'b0, "after_reset");
   endtask

   task automatic test_random(input int count);
      logic [WB-1:0] xv, yv, nv, mask, exp;
      int k, lv, t;
      bit chain;
      chain = 1'b0;
      for (int op = 0; op < count; op++) begin
         if (op >= count - 8) begin
            k  = $urandom_range(2047, 2040);
            lv = 2047;
         end else begin
            k  = $urandom_range(60, 1);
            lv = k + $urandom_range(3, 0);
         end
         mask = '1;
         mask = mask >> (WB - 1 - k);
         nv = rand_wide() & mask;
         nv[k] = 1'b1;
         nv[0] = 1'b1;
         xv  = (rand_wide() & mask) % nv;
         yv  = (rand_wide() & mask) % nv;
         exp = ref_mont(xv, yv, nv, lv + 1);
         if (!chain) repeat ($urandom_range(2, 0)) tick();
         w_x = xv; w_y = yv; w_n = nv; w_len = LB'(lv); w_start = 1'b1;
         tick();
         w_start = 1'b0;
         w_x = rand_wide(); w_y = rand_wide(); w_n = rand_wide(); w_len = LB'($urandom);
         t = 0;
         while (w_done !== 1'b1 && t < lv + 10) begin
            tick();
            t++;
         end
         n_checks++;
         if (w_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rnd%0d done: not seen within %0d cycles", op, t);
            break;
         end
         n_checks++;
         if (t != lv + 2) begin
            n_fail++; $display("FAIL rnd%0d latency: got %0d expected %0d", op, t, lv + 2);
         end
         n_checks++;
         if (w_result !== exp) begin
            n_fail++;
            $display("FAIL rnd%0d result (n_len=%0d): got low %h expected low %h",
                     op, lv, w_result[63:0], exp[63:0]);
         end
         n_checks++;
         if (!(w_result < nv)) begin
            n_fail++; $display("FAIL rnd%0d reduced: got low %h not below n", op, w_result[63:0]);
         end
         chain = 1'($urandom_range(1, 0));
      end
   endtask

   initial begin
      s_start = 1'b0; s_abort = 1'b0; s_x = '0; s_y = '0; s_n = '0; s_len = '0;
      w_start = 1'b0; w_abort = 1'b0; w_x = '0; w_y = '0; w_n = '0; w_len = '0;
      test_reset();
      test_basic();
      test_values();
      test_start_ignored();
      test_abort();
      test_reset_mid();
      test_random(500);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mont_mul_param.md
# mont_mul_param

Parametrised, handshaked radix-2 Montgomery multiplier for the RSA datapath. It computes x·y·2^-(n_len+1) mod n with a fully reduced result, over a configurable operand width. Sits between the modular-exponentiation controller and the operand register file. Supersedes the fixed 2048-bit multiplier with start/busy/done handshaking, operand latching, abort, a clean active-low asynchronous reset, and a guaranteed result < n.

## Interface
- WIDTH, 2048, operand and modulus width in bits.
- LEN_W, $clog2(WIDTH), width of n_len.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  synchronous cancel of a running operation.
- x  in  WIDTH  multiplicand; latched on accepted start.
- y  in  WIDTH  multiplier; latched on accepted start.
- n  in  WIDTH  odd modulus; latched on accepted start.
- n_len  in  LEN_W  MSB index of n (bit length − 1); latched on accepted start.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  x·y·2^-(n_len+1) mod n; holds until the next done.

## Operation
- States: IDLE, MUL, SUB. Encoding 2 bits; the unused code goes to IDLE.
- Reset (rst_n low, async): state=IDLE, busy=0, done=0, result=0, accumulator A=0, counter i=0, operand registers=0.
- IDLE: when start=1, latch x, y, n, n_len. Clear A and i, then go to MUL. When start=0, stay in IDLE.
- MUL, per cycle: q = A[0] ^ (x[i] & y[0]); A ← (A + x[i]·y + q·n) >> 1. If i == n_len, go to SUB; otherwise i ← i+1.
- SUB: if A ≥ n, result ← A − n; otherwise result ← A[WIDTH-1:0]. Pulse done for one cycle and return to IDLE.
- Arithmetic width: A is WIDTH+2 bits. The pre-shift sum uses WIDTH+3 bits, so no overflow occurs. For x, y < n, A < 2n after MUL, so one subtraction always suffices.
- n_len > WIDTH−1 saturates to WIDTH−1 at latch time.
- Iteration count is n_len+1, independent of operand values.
- Preconditions are n odd and x, y < n. If they are violated, result is unspecified, but cycle timing, done and busy still behave as specified.
- abort=1 in MUL or SUB: return to IDLE next cycle. No done pulse; result is unchanged. abort in IDLE has no effect.
- abort and start both high in IDLE: start wins.
- start while busy: ignored, with no queueing and no corruption of latched operands.
- Input changes after an accepted start have no effect on the running operation.

## Timing
- Start accepted at edge E0. MUL occupies edges E1..E(n_len+1). SUB occurs at edge E(n_len+2).
- done and the new result are visible in the cycle following E(n_len+2). Latency is n_len+2 cycles from the start edge. For n_len=3, done is high 5 cycles after the start cycle.
- busy rises the cycle after E0 and falls in the same cycle done rises.
- Back-to-back: start high in the done cycle is accepted. Throughput is one operation per n_len+3 cycles.
- rst_n deassertion is synchronised externally. There is no cycle-level requirement on release beyond staying in IDLE.
- rst_n asserted mid-operation: every output returns to its reset value immediately.

## Structure
- Shared package mont_pkg holds:
  - the state typedef: IDLE, MUL, SUB;
  - a helper function computing LEN_W from WIDTH.
- The exponentiation controller imports mont_pkg.
- One combinational sub-module, mont_step, computes one iteration:
  - inputs: A, x_bit, y, n;
  - output: next A.
  - It is isolated so it can later be replaced by a higher-radix or carry-save step without touching the FSM.
- The FSM, counter, operand latches and final subtraction stay in mont_mul_param.

## Test plan
- WIDTH=8, n=13, n_len=3, x=5, y=7, start → done exactly 5 cycles after the start cycle, result=3, busy high for 5 cycles.
- WIDTH=8, n=13, n_len=3, x=12, y=12 → result=9. With x=0, y=7 → result=0. Check that result < n in every case.
- Start pulsed again 2 cycles into an operation, with x/y/n changed on the inputs → ignored. The first result is unaffected and exactly one done pulse occurs.
- abort in cycle 3 of MUL → busy drops next cycle, no done, result keeps its previous value. A fresh start then completes normally.
- rst_n low mid-MUL → busy=0, done=0, result=0 asynchronously. After release, a new start with n=13, x=5, y=7 yields 3.
- WIDTH=2048, 500 random odd n with x, y < n and random n_len ≥ the true MSB index of n, including back-to-back starts in the done cycle → every result matches the model x·y·2^-(n_len+1) mod n.
